imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/risc_pkg.sv | 26 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// ============================================================================
// Module      : risc_pkg
// Description : Shared word width and instruction-loader state encoding.
//               IMEM_LOADER_CHECKSUM_EN adds the checksum state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK  = 3'd2,
`endif
        ST_HOLD = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Streams a length-prefixed program into instruction memory and
//               holds the core in reset until the load completes. Defining
//               IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import risc_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // One extra bit so a full-depth length (2^ADDR_W) is representable.
    localparam int               LEN_W = ADDR_W + 1;
    localparam int               CNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [LEN_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t POST_LOAD = ST_CHK;
`else
    localparam loader_state_t POST_LOAD = ST_HOLD;
`endif

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  index;
    logic [CNT_W-1:0]  hold_cnt;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR: begin
                if (accept) begin
                    if (in_data == '0)
                        state_nxt = POST_LOAD;
                    else if (in_data > WORD_W'(DEPTH))
                        state_nxt = ST_ERR;
                    else
                        state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && (index == len - LEN_W'(1)))
                    state_nxt = POST_LOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept)
                    state_nxt = (in_data == sum) ? ST_HOLD : ST_ERR;
            end
`endif
            ST_HOLD: begin
                if (hold_cnt == CNT_W'(HOLD_CYC - 1))
                    state_nxt = ST_RUN;
            end
            default: state_nxt = state;
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state itself; in_ready therefore drops on the edge that
    // accepts the final word and no extra word can slip in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HDR;
            len        <= '0;
            index      <= '0;
            hold_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state   <= state_nxt;
            imem_we <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (accept) begin
                        len   <= in_data[LEN_W-1:0];
                        index <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= index[ADDR_W-1:0];
                        imem_wdata <= in_data;
                        index      <= index + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum        <= sum + in_data;
`endif
                    end
                end
                ST_HOLD: hold_cnt <= hold_cnt + CNT_W'(1);
                default: ;
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready  <= (state_nxt == ST_HDR) || (state_nxt == ST_LOAD) ||
                         (state_nxt == ST_CHK);
`else
            in_ready  <= (state_nxt == ST_HDR) || (state_nxt == ST_LOAD);
`endif
            cpu_reset <= (state_nxt != ST_RUN);
            done      <= (state_nxt == ST_RUN);
            error     <= (state_nxt == ST_ERR);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (honours
//               IMEM_LOADER_CHECKSUM_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W   = 8;
    localparam int HOLD_CYC = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    localparam int P_HDR  = 0;
    localparam int P_LOAD = 1;
    localparam int P_CHK  = 2;
    localparam int P_HOLD = 3;
    localparam int P_RUN  = 4;
    localparam int P_ERR  = 5;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              in_valid = 1'b0;
    logic [31:0]       in_data  = '0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model: phase of the load protocol plus expected write port.
    int          m_phase;
    int unsigned m_len, m_idx, m_hold;
    logic [31:0] m_sum;
    bit          m_fresh;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    bit          pend_hs  = 1'b0;
    logic [31:0] pend_data = '0;
    bit          prev_rst = 1'b1;

    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = P_HDR; m_len = 0; m_idx = 0; m_hold = 0; m_sum = '0;
        m_fresh = 1'b1; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    endfunction

    function automatic void enter_hold();
        m_phase = P_HOLD;
        m_hold  = HOLD_CYC;
    endfunction

    function automatic void after_payload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        m_phase = P_CHK;
`else
        enter_hold();
`endif
    endfunction

    function automatic void model_step(input bit hs, input logic [31:0] d);
        m_we = 1'b0;
        if (m_phase == P_HOLD) begin
            m_hold--;
            if (m_hold == 0) m_phase = P_RUN;
        end else if (hs) begin
            case (m_phase)
                P_HDR: begin
                    m_sum = '0; m_idx = 0; m_len = d;
                    if (d == 0)          after_payload();
                    else if (d > DEPTH)  m_phase = P_ERR;
                    else                 m_phase = P_LOAD;
                end
                P_LOAD: begin
                    m_we = 1'b1; m_addr = m_idx[7:0]; m_wdata = d;
                    m_sum = m_sum + d;
                    m_idx++;
                    if (m_idx == m_len) after_payload();
                end
                P_CHK: begin
                    if (d == m_sum) enter_hold();
                    else            m_phase = P_ERR;
                end
                default: ;
            endcase
        end
        m_fresh = 1'b0;
    endfunction

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        logic [44:0] act, exp;
        logic        rdy_e;
        cyc++;
        if (reset)          model_reset();
        else if (!prev_rst) model_step(pend_hs, pend_data);
        rdy_e = !reset && !m_fresh &&
                (m_phase == P_HDR || m_phase == P_LOAD || m_phase == P_CHK);
        exp = {rdy_e, m_we, m_addr, m_wdata, m_phase != P_RUN,
               m_phase == P_RUN, m_phase == P_ERR};
        act = {in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error};
        chk("outputs{rdy,we,addr,wdata,cpurst,done,err}", 64'(act), 64'(exp));
        chk("done_and_error_exclusive", 64'(done && error), 64'(0));
        if (!reset && imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cyc);
        end
        pend_hs   = in_valid && in_ready && !reset;
        pend_data = in_data;
        prev_rst  = reset;
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_log();
    endtask

    // Presents one word and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [31:0] w);
        int t = 0;
        in_valid = 1'b1; in_data = w;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(0), 64'(1));
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (cpu_reset && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Back-to-back three-word program.
        send(32'd3);
        send(32'h20010005); send(32'h20020007); send(32'h00221820);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(32'h20010005 + 32'h20020007 + 32'h00221820);
`endif
        wait_release(n);
        chk("b2b_hold_cycles", 64'(n), 64'(4));
        chk("b2b_done", 64'(done), 64'(1));
        chk("b2b_nwrites", 64'(log_addr.size()), 64'(3));
        if (log_addr.size() == 3) begin
            chk("b2b_addr0", 64'(log_addr[0]), 64'(0));
            chk("b2b_addr2", 64'(log_addr[2]), 64'(2));
            chk("b2b_data1", 64'(log_data[1]), 64'h20020007);
            chk("b2b_data2", 64'(log_data[2]), 64'h00221820);
            chk("b2b_consecutive", 64'(log_cyc[2] - log_cyc[0]), 64'(2));
        end

        // Gapped two-word program.
        do_reset();
        send(32'd2);
        send(32'hAAAA0001);
        repeat (3) @(posedge clk);
        #1;
        send(32'hBBBB0002);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(32'hAAAA0001 + 32'hBBBB0002);
`endif
        wait_release(n);
        chk("gap_nwrites", 64'(log_addr.size()), 64'(2));
        if (log_addr.size() == 2) begin
            chk("gap_addr1", 64'(log_addr[1]), 64'(1));
            chk("gap_data0", 64'(log_data[0]), 64'hAAAA0001);
        end

        // Oversize headers.
        do_reset();
        send(32'h00000101);
        repeat (6) @(posedge clk);
        #1;
        chk("ovf_error", 64'(error), 64'(1));
        chk("ovf_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("ovf_nwrites", 64'(log_addr.size()), 64'(0));
        do_reset();
        send(32'hFFFFFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_max_error", 64'(error), 64'(1));

        // Reset in the middle of a load, then a fresh single-word load.
        do_reset();
        send(32'd5); send(32'h11111111); send(32'h22222222);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_outputs", 64'({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error}),
            64'({1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}));
        @(posedge clk); #1;
        reset = 1'b0;
        clear_log();
        send(32'd1); send(32'hCAFEF00D);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(32'hCAFEF00D);
`endif
        wait_release(n);
        chk("midrst_nwrites", 64'(log_addr.size()), 64'(1));
        if (log_addr.size() == 1) begin
            chk("midrst_addr", 64'(log_addr[0]), 64'(0));
            chk("midrst_data", 64'(log_data[0]), 64'hCAFEF00D);
        end

        // Empty program.
        do_reset();
        send(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(32'd0);
`endif
        wait_release(n);
        chk("empty_hold_cycles", 64'(n), 64'(HOLD_CYC));
        chk("empty_done", 64'(done), 64'(1));
        chk("empty_nwrites", 64'(log_addr.size()), 64'(0));

        // Full-depth program.
        do_reset();
        begin
            logic [31:0] s = '0;
            send(32'd256);
            for (int i = 0; i < DEPTH; i++) begin
                send(32'(i * 3 + 1));
                s = s + 32'(i * 3 + 1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send(s);
`endif
        end
        wait_release(n);
        chk("full_done", 64'(done), 64'(1));
        chk("full_nwrites", 64'(log_addr.size()), 64'(256));
        if (log_addr.size() == 256) begin
            chk("full_last_addr", 64'(log_addr[255]), 64'(255));
            chk("full_last_data", 64'(log_data[255]), 64'(766));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        send(32'd2); send(32'd1); send(32'd2); send(32'd3);
        wait_release(n);
        chk("cks_good_done", 64'(done), 64'(1));
        do_reset();
        send(32'd2); send(32'd1); send(32'd2); send(32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("cks_bad_error", 64'(error), 64'(1));
        chk("cks_bad_cpu_reset", 64'(cpu_reset), 64'(1));
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
